fetch_unit: RTL and testbench

Fetch stage of the single-cycle autograder datapath. Owns the program counter and computes the next PC from the sequential, branch, jump and jump-register (jalr) selects. Drives the instruction-memory address and the link value (PC+4). Detects the all-zero end-of-program instruction and freezes the machine in a halted state.

---
 rtl/fetch_unit_if.sv | 37 +++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the fetch-stage control and result signals.
//   Decode/control side (master) drives: stall, inst_in, branch_taken,
//     branch_offset, jump, jump_index, jump_reg, jump_reg_target.
//   Fetch unit (slave) drives: pc, pc_plus4, inst, halted, misaligned,
//     retired_count, state_dbg (current FSM state, 0 = RUN, 1 = HALT).
// There is no valid/ready pair: every input is sampled on each rising
// clock edge, and stall is the only flow control. stall = 1 holds the PC
// and the retire counter for that cycle.
interface fetch_unit_if;
    logic        stall;
    logic [31:0] inst_in;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jump_reg_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
    logic        halted;
    logic        misaligned;
    logic [31:0] retired_count;
    logic        state_dbg;

    modport master (
        output stall, inst_in, branch_taken, branch_offset, jump, jump_index,
               jump_reg, jump_reg_target,
        input  pc, pc_plus4, inst, halted, misaligned, retired_count, state_dbg
    );

    modport slave (
        input  stall, inst_in, branch_taken, branch_offset, jump, jump_index,
               jump_reg, jump_reg_target,
        output pc, pc_plus4, inst, halted, misaligned, retired_count, state_dbg
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage of a single-cycle datapath.
//   It holds the word PC and selects the next PC with this priority:
//   jump_reg > jump > branch > sequential. It detects an all-zero
//   instruction and then freezes in HALT until reset.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - fetch_unit_if.slave (selects/instruction in; pc, pc_plus4, inst,
//           halted, misaligned, retired_count and state_dbg out)
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.slave   bus
);
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        mis_q, mis_d;

    // The PC is held as a word address. All targets are formed at word
    // granularity, so the low two bits of pc are 0 by construction.
    logic [29:0] pc_inc_w;
    logic [29:0] br_target_w;
    logic [29:0] j_target_w;
    logic        is_zero_inst;

    assign pc_inc_w     = pc_q + 30'd1;
    assign br_target_w  = pc_inc_w + {{14{bus.branch_offset[15]}}, bus.branch_offset};
    assign j_target_w   = {pc_inc_w[29:26], bus.jump_index};
    assign is_zero_inst = HALT_ON_ZERO && (bus.inst_in == 32'h0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        if (state_q == RUN && !bus.stall) begin
            if (is_zero_inst) begin
                // The end-of-program marker is not retired, and the PC stays on it.
                state_d = HALT;
            end else begin
                cnt_d = cnt_q + 32'd1;
                if (bus.jump_reg) begin
                    pc_d  = bus.jump_reg_target[31:2];
                    mis_d = (bus.jump_reg_target[1:0] != 2'b00);
                end else if (bus.jump) begin
                    pc_d = j_target_w;
                end else if (bus.branch_taken) begin
                    pc_d = br_target_w;
                end else begin
                    pc_d = pc_inc_w;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC[31:2];
            cnt_q   <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.pc            = {pc_q, 2'b00};
    assign bus.pc_plus4      = {pc_inc_w, 2'b00};
    assign bus.inst          = bus.inst_in;
    assign bus.halted        = (state_q == HALT);
    assign bus.misaligned    = mis_q;
    assign bus.retired_count = cnt_q;
    assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0020;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [31:0] inst;
        logic        br;
        logic [15:0] off;
        logic        jmp;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] tgt;
        logic [31:0] pre_pc4;
        logic [31:0] exp_pc;
        logic        exp_h;
        logic        exp_m;
        logic [31:0] exp_cnt;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0040_0000), .HALT_ON_ZERO(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- helpers ----------------
    function automatic vec_t mk(logic rst, logic stall, logic [31:0] inst,
                                logic br, logic [15:0] off, logic jmp,
                                logic [25:0] idx, logic jr, logic [31:0] tgt,
                                logic [31:0] pre_pc4, logic [31:0] exp_pc,
                                logic exp_h, logic exp_m, logic [31:0] exp_cnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.inst = inst; v.br = br; v.off = off;
        v.jmp = jmp; v.idx = idx; v.jr = jr; v.tgt = tgt; v.pre_pc4 = pre_pc4;
        v.exp_pc = exp_pc; v.exp_h = exp_h; v.exp_m = exp_m; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input vec_t v);
        reset               = v.rst;
        bus.stall           = v.stall;
        bus.inst_in         = v.inst;
        bus.branch_taken    = v.br;
        bus.branch_offset   = v.off;
        bus.jump            = v.jmp;
        bus.jump_index      = v.idx;
        bus.jump_reg        = v.jr;
        bus.jump_reg_target = v.tgt;
    endtask

    // Drive on the falling edge, check the combinational outputs before the
    // rising edge, and check the registered outputs 1 time unit after it.
    task automatic apply_vec(input int i, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        if (!v.rst) chk($sformatf("v%0d pc_plus4_pre", i), bus.pc_plus4, v.pre_pc4);
        chk($sformatf("v%0d inst", i), bus.inst, v.inst);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d pc", i), bus.pc, v.exp_pc);
        chk($sformatf("v%0d pc_plus4", i), bus.pc_plus4, v.exp_pc + 32'd4);
        chk($sformatf("v%0d halted", i), {31'd0, bus.halted}, {31'd0, v.exp_h});
        chk($sformatf("v%0d misaligned", i), {31'd0, bus.misaligned}, {31'd0, v.exp_m});
        chk($sformatf("v%0d retired", i), bus.retired_count, v.exp_cnt);
    endtask

    vec_t tab[26];

    initial begin
        //             rst stl inst   br off       jmp idx          jr tgt            pre_pc4       exp_pc        h  m  cnt
        tab[0]  = mk(1, 0, NOP,   0, 16'h0000, 0, 26'h0,       0, 32'h0,          32'h0,         32'h0040_0000, 0, 0, 0);
        tab[1]  = mk(0, 0, NOP,   0, 16'h0000, 0, 26'h0,       0, 32'h0,          32'h0040_0004, 32'h0040_0004, 0, 0, 1);
        tab[2]  = mk(0, 0, NOP,   0, 16'h0000, 0, 26'h0,       0, 32'h0,          32'h0040_0008, 32'h0040_0008, 0, 0, 2);
        tab[3]  = mk(0, 0, NOP,   0, 16'h0000, 0, 26'h0,       0, 32'h0,          32'h0040_000C, 32'h0040_000C, 0, 0, 3);
        tab[4]  = mk(1, 0, NOP,   0, 16'h0000, 0, 26'h0,       0, 32'h0,          32'h0,         32'h0040_0000, 0, 0, 0);
        // jalr to an aligned target, then to a misaligned one, then a sequential step
        tab[5]  = mk(0, 0, NOP,   0, 16'h0000, 0, 26'h0,       1, 32'h0040_0008,  32'h0040_0004, 32'h0040_0008, 0, 0, 1);
        tab[6]  = mk(0, 0, NOP,   0, 16'h0000, 0, 26'h0,       1, 32'h0040_000B,  32'h0040_000C, 32'h0040_0008, 0, 1, 2);
        tab[7]  = mk(0, 0, NOP,   0, 16'h0000, 0, 26'h0,       0, 32'h0,          32'h0040_000C, 32'h0040_000C, 0, 0, 3);
        // all three selects: jump_reg wins
        tab[8]  = mk(0, 0, NOP,   1, 16'h0010, 1, 26'h3FF_FFFF, 1, 32'h0040_0000, 32'h0040_0010, 32'h0040_0000, 0, 0, 4);
        tab[9]  = mk(0, 0, NOP,   0, 16'h0000, 1, 26'h010_0010, 0, 32'h0,         32'h0040_0004, 32'h0040_0040, 0, 0, 5);
        tab[10] = mk(0, 0, NOP,   0, 16'h0000, 0, 26'h0,       1, 32'h0040_0010,  32'h0040_0044, 32'h0040_0010, 0, 0, 6);
        // negative branch offset: 0x00400014 - 16
        tab[11] = mk(0, 0, NOP,   1, 16'hFFFC, 0, 26'h0,       0, 32'h0,          32'h0040_0014, 32'h0040_0004, 0, 0, 7);
        // jump beats branch
        tab[12] = mk(0, 0, NOP,   1, 16'h0004, 1, 26'h010_0003, 0, 32'h0,         32'h0040_0008, 32'h0040_000C, 0, 0, 8);
        // zero instruction at 0x0040000C halts; the PC holds and it is not retired
        tab[13] = mk(0, 0, 32'h0, 0, 16'h0000, 1, 26'h0,       0, 32'h0,          32'h0040_0010, 32'h0040_000C, 1, 0, 8);
        // stall holds everything and suppresses halt detection
        tab[14] = mk(1, 0, NOP,   0, 16'h0000, 0, 26'h0,       0, 32'h0,          32'h0,         32'h0040_0000, 0, 0, 0);
        tab[15] = mk(0, 0, NOP,   0, 16'h0000, 0, 26'h0,       0, 32'h0,          32'h0040_0004, 32'h0040_0004, 0, 0, 1);
        tab[16] = mk(0, 1, 32'h0, 0, 16'h0000, 1, 26'h0,       0, 32'h0,          32'h0040_0008, 32'h0040_0004, 0, 0, 1);
        tab[17] = mk(0, 1, 32'h0, 0, 16'h0000, 1, 26'h0,       0, 32'h0,          32'h0040_0008, 32'h0040_0004, 0, 0, 1);
        tab[18] = mk(0, 1, 32'h0, 0, 16'h0000, 1, 26'h0,       0, 32'h0,          32'h0040_0008, 32'h0040_0004, 0, 0, 1);
        tab[19] = mk(0, 0, 32'h0, 0, 16'h0000, 1, 26'h0,       0, 32'h0,          32'h0040_0008, 32'h0040_0004, 1, 0, 1);
        // pc_plus4 wraps at the top of the address space
        tab[20] = mk(1, 0, NOP,   0, 16'h0000, 0, 26'h0,       0, 32'h0,          32'h0,         32'h0040_0000, 0, 0, 0);
        tab[21] = mk(0, 0, NOP,   0, 16'h0000, 0, 26'h0,       1, 32'hFFFF_FFFC,  32'h0040_0004, 32'hFFFF_FFFC, 0, 0, 1);
        tab[22] = mk(0, 0, NOP,   0, 16'h0000, 0, 26'h0,       0, 32'h0,          32'h0000_0000, 32'h0000_0000, 0, 0, 2);
        // misaligned pulse followed by a stall cycle: the flag clears
        tab[23] = mk(0, 0, NOP,   0, 16'h0000, 0, 26'h0,       1, 32'h0000_0007,  32'h0000_0004, 32'h0000_0004, 0, 1, 3);
        tab[24] = mk(0, 1, NOP,   0, 16'h0000, 0, 26'h0,       1, 32'h0000_0007,  32'h0000_0008, 32'h0000_0004, 0, 0, 3);
        // reset during a stall still reloads
        tab[25] = mk(1, 1, NOP,   0, 16'h0000, 0, 26'h0,       0, 32'h0,          32'h0,         32'h0040_0000, 0, 0, 0);

        for (int i = 0; i <= 13; i++) apply_vec(i, tab[i]);

        // In HALT, the selects, instruction and stall are all ignored for 12 cycles.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            reset               = 1'b0;
            bus.stall           = 1'($urandom_range(0, 1));
            bus.inst_in         = (k % 2 == 0) ? 32'h0 : $urandom;
            bus.branch_taken    = 1'($urandom_range(0, 1));
            bus.branch_offset   = 16'($urandom);
            bus.jump            = 1'($urandom_range(0, 1));
            bus.jump_index      = 26'($urandom);
            bus.jump_reg        = 1'b1;
            bus.jump_reg_target = $urandom | 32'h1;
            @(posedge clk);
            #1;
            chk($sformatf("halt%0d pc", k), bus.pc, 32'h0040_000C);
            chk($sformatf("halt%0d halted", k), {31'd0, bus.halted}, 32'd1);
            chk($sformatf("halt%0d misaligned", k), {31'd0, bus.misaligned}, 32'd0);
            chk($sformatf("halt%0d retired", k), bus.retired_count, 32'd8);
        end

        for (int i = 14; i <= 25; i++) apply_vec(i, tab[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
